// File: rtl/pattern_moore_pkg.sv
// pattern_moore_pkg: shared defaults, default state encoding and KMP transition builder.
package pattern_moore_pkg;
    localparam int DEF_PAT_LEN = 2;
    localparam logic [15:0] DEF_PATTERN = 16'b01;
    localparam int DEF_SW = $clog2(DEF_PAT_LEN + 1);

    typedef enum logic [DEF_SW-1:0] {S0 = 0, S1 = 1, S_MATCH = 2} state_t;

    // Next state from Sk on bit b: longest pattern prefix that is a suffix of (prefix_k, b).
    function automatic int fallback(input int k, input logic b, input logic [15:0] pattern, input int len);
        int best;
        logic ok;
        logic s;
        int m;
        best = 0;
        if (k > len) return 0;
        for (int j = 1; j <= len && j <= k + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                m = k + 1 - j + i;
                if (m == k) s = b;
                else s = pattern[len - 1 - m];
                if (s != pattern[len - 1 - i]) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction
endpackage

// File: rtl/pattern_moore_if.sv
// pattern_moore_if: serial input / match flag bundle; match_count present only with PATTERN_MOORE_COUNT_EN.
interface pattern_moore_if;
    logic a;
    logic y;
`ifdef PATTERN_MOORE_COUNT_EN
    logic [15:0] match_count;
    modport master(output a, input y, input match_count);
    modport slave(input a, output y, output match_count);
`else
    modport master(output a, input y);
    modport slave(input a, output y);
`endif
endinterface

// File: rtl/pattern_moore_counter.sv
// pattern_moore_counter: 16-bit saturating match counter, cleared by reset.
module pattern_moore_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk)
        if (reset) count <= '0;
        else if (inc && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/pattern_moore.sv
// pattern_moore: Moore serial pattern recognizer with KMP fallback (overlapping matches).
// Optional saturating match counter enabled by defining PATTERN_MOORE_COUNT_EN.
module pattern_moore
    import pattern_moore_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input logic clk,
    input logic reset,
    pattern_moore_if.slave bus
);
    localparam int SW = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0] st0 = '0;
    localparam logic [SW-1:0] st_match = SW'(PAT_LEN);

    logic [SW-1:0] state, nxt;
    logic [SW-1:0] tab0 [2**SW];
    logic [SW-1:0] tab1 [2**SW];

    // Encodings above S_MATCH are illegal and map straight back to S0.
    for (genvar k = 0; k < 2**SW; k++) begin : g_tab
        assign tab0[k] = (k <= PAT_LEN) ? SW'(fallback(k, 1'b0, 16'(PATTERN), PAT_LEN)) : st0;
        assign tab1[k] = (k <= PAT_LEN) ? SW'(fallback(k, 1'b1, 16'(PATTERN), PAT_LEN)) : st0;
    end

    assign nxt = bus.a ? tab1[state] : tab0[state];

    always_ff @(posedge clk)
        if (reset) state <= st0;
        else state <= nxt;

    assign bus.y = (state == st_match);

`ifdef PATTERN_MOORE_COUNT_EN
    pattern_moore_counter u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (nxt == st_match),
        .count(bus.match_count)
    );
`endif
endmodule

// File: tb/tb_pattern_moore.sv
// tb_pattern_moore: directed vector table plus hand sequences for the default "01" pattern.
module tb_pattern_moore;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;

    pattern_moore_if bus();
    pattern_moore dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic a;
        logic y;
    } vec_t;

    vec_t vecs [16];

    task automatic step(input logic r, input logic a, input logic y_exp, input string name);
        reset = r;
        bus.a = a;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.y !== y_exp) begin
            bad++;
            $display("FAIL %s: y=%b expected %b", name, bus.y, y_exp);
        end
    endtask

`ifdef PATTERN_MOORE_COUNT_EN
    task automatic chk_cnt(input logic [15:0] exp, input string name);
        total++;
        if (bus.match_count !== exp) begin
            bad++;
            $display("FAIL %s: match_count=%0d expected %0d", name, bus.match_count, exp);
        end
    endtask
`endif

    initial begin
        vecs = '{
            '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1}
        };
        reset = 1'b1;
        bus.a = 1'b1;
        for (int i = 0; i < 16; i++)
            step(vecs[i].r, vecs[i].a, vecs[i].y, $sformatf("vec%0d", i));
        step(1'b0, 1'b1, 1'b0, "match_exit_1");
        step(1'b0, 1'b1, 1'b0, "s0_hold_1");
        step(1'b0, 1'b0, 1'b0, "mid_prefix");
        step(1'b1, 1'b1, 1'b0, "reset_mid_match");
        step(1'b0, 1'b1, 1'b0, "after_reset_1");
        step(1'b0, 1'b1, 1'b0, "after_reset_11");
`ifdef PATTERN_MOORE_COUNT_EN
        step(1'b1, 1'b0, 1'b0, "cnt_reset");
        chk_cnt(16'd0, "cnt_after_reset");
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'(i % 2), 1'(i % 2), $sformatf("cnt_stream%0d", i));
        chk_cnt(16'd3, "cnt_three");
        step(1'b1, 1'b1, 1'b0, "cnt_reset2");
        chk_cnt(16'd0, "cnt_cleared");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
